// File: rtl/l2_pkg.sv
// Shared definitions for the L2 responder slice: default geometry, hit latency
// and the controller state encoding.
package l2_pkg;

  localparam int unsigned L2_ADDR_W  = 26;
  localparam int unsigned L2_INDEX_W = 8;
  localparam int unsigned L2_HIT_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_HIT_WAIT = 3'd2,
    S_WB       = 3'd3,
    S_FILL     = 3'd4,
    S_RESP     = 3'd5,
    S_DONE     = 3'd6
  } l2_state_t;

endpackage

// File: rtl/l2_tag_array.sv
// Direct-mapped L2 tag/valid/dirty store: combinational read port, one
// synchronous write port, asynchronous clear of every entry.
module l2_tag_array
  import l2_pkg::*;
#(
  parameter int unsigned INDEX_W = L2_INDEX_W,
  parameter int unsigned TAG_W   = L2_ADDR_W - L2_INDEX_W
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               line_we,
  input  logic [TAG_W-1:0]   line_tag,
  input  logic               dirty_we,
  input  logic               dirty_val
);

  localparam int unsigned DEPTH = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_arr [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] dirty;

  assign rd_tag   = tag_arr[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];

  // line_we installs a tag and marks it valid; dirty has its own enable so a
  // write-back can clear it without touching the tag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_arr[i] <= '0;
      end
      valid <= '0;
      dirty <= '0;
    end else begin
      if (line_we) begin
        tag_arr[wr_idx] <= line_tag;
        valid[wr_idx]   <= 1'b1;
      end
      if (dirty_we) begin
        dirty[wr_idx] <= dirty_val;
      end
    end
  end

endmodule

// File: rtl/l2_l1_responder.sv
// L2 control block answering L1 block read/write-back requests; fetches from
// memory on a miss after writing back a dirty victim.
module l2_l1_responder
  import l2_pkg::*;
#(
  parameter int unsigned ADDR_W  = L2_ADDR_W,
  parameter int unsigned INDEX_W = L2_INDEX_W,
  parameter int unsigned HIT_LAT = L2_HIT_LAT
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               read_L1_L2,
  input  logic               write_L1_L2,
  input  logic [ADDR_W-1:0]  addr_L1_L2,
  output logic               ready_L2_L1,
  output logic               read_L2_MEM,
  output logic               write_L2_MEM,
  output logic [ADDR_W-1:0]  addr_L2_MEM,
  input  logic               ready_MEM_L2,
  output logic               refill_L2,
  output logic               update_L2,
  output logic [INDEX_W-1:0] index_L2
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;
  localparam int unsigned CNT_W = (HIT_LAT > 1) ? $clog2(HIT_LAT) : 1;

  l2_state_t          state, state_nx;
  logic [ADDR_W-1:0]  cap_addr;
  logic               cap_write;
  logic [CNT_W-1:0]   hit_cnt;

  logic [INDEX_W-1:0] cap_idx;
  logic [TAG_W-1:0]   cap_tag;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;
  logic               rd_dirty;
  logic               tag_eq;
  logic               hit;
  logic               line_we;
  logic               dirty_we;
  logic               dirty_val;

  assign cap_idx = cap_addr[INDEX_W-1:0];
  assign cap_tag = cap_addr[ADDR_W-1:INDEX_W];
  assign tag_eq  = (rd_tag == cap_tag);
  assign hit     = rd_valid && tag_eq;

  l2_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tags (
    .clk       (clk),
    .nrst      (nrst),
    .rd_idx    (cap_idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .wr_idx    (cap_idx),
    .line_we   (line_we),
    .line_tag  (cap_tag),
    .dirty_we  (dirty_we),
    .dirty_val (dirty_val)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Write wins when both requests are up; the read level stays high and is
  // picked up on the next pass through S_IDLE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cap_addr  <= '0;
      cap_write <= 1'b0;
    end else if (state == S_IDLE && (read_L1_L2 || write_L1_L2)) begin
      cap_addr  <= addr_L1_L2;
      cap_write <= write_L1_L2;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit_cnt <= '0;
    end else if (state == S_HIT_WAIT) begin
      hit_cnt <= hit_cnt + 1'b1;
    end else begin
      hit_cnt <= '0;
    end
  end

  always_comb begin
    state_nx  = state;
    line_we   = 1'b0;
    dirty_we  = 1'b0;
    dirty_val = 1'b0;
    case (state)
      S_IDLE: begin
        if (read_L1_L2 || write_L1_L2) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (cap_write) begin
          // A full-line write never needs a fill, only a foreign dirty victim out.
          state_nx = (rd_valid && rd_dirty && !tag_eq) ? S_WB : S_RESP;
        end else if (hit) begin
          state_nx = (HIT_LAT == 0) ? S_RESP : S_HIT_WAIT;
        end else begin
          state_nx = (rd_valid && rd_dirty) ? S_WB : S_FILL;
        end
      end
      S_HIT_WAIT: begin
        if (hit_cnt == CNT_W'(HIT_LAT - 1)) state_nx = S_RESP;
      end
      S_WB: begin
        if (ready_MEM_L2) begin
          dirty_we  = 1'b1;
          dirty_val = 1'b0;
          state_nx  = cap_write ? S_RESP : S_FILL;
        end
      end
      S_FILL: begin
        if (ready_MEM_L2) begin
          line_we   = 1'b1;
          dirty_we  = 1'b1;
          dirty_val = 1'b0;
          state_nx  = S_RESP;
        end
      end
      S_RESP: begin
        if (cap_write) begin
          line_we   = 1'b1;
          dirty_we  = 1'b1;
          dirty_val = 1'b1;
        end
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign ready_L2_L1  = (state == S_RESP);
  assign update_L2    = (state == S_RESP) && cap_write;
  assign write_L2_MEM = (state == S_WB);
  assign read_L2_MEM  = (state == S_FILL);
  assign refill_L2    = (state == S_FILL) && ready_MEM_L2;
  assign index_L2     = cap_idx;

  always_comb begin
    addr_L2_MEM = '0;
    case (state)
      S_WB:    addr_L2_MEM = {rd_tag, cap_idx};
      S_FILL:  addr_L2_MEM = cap_addr;
      default: addr_L2_MEM = '0;
    endcase
  end

endmodule

// File: doc/l2_l1_responder.md
# l2_l1_responder

L2-side control block that answers block requests issued by the L1 cache controllers over the `read_L1_L2` / `write_L1_L2` / `ready_L2_L1` interface. It owns a direct-mapped L2 tag/valid/dirty store. On a miss it fetches from main memory, writing back a dirty victim first. It drives the L2 data-array strobes but holds no data itself, and sits between the L1 controllers and the memory interface.

## Interface
- `ADDR_W`, 26: block address width, equal to the L1 `{tag[19:0], index[5:0]}`.
- `INDEX_W`, 8: L2 index width, 256 sets; L2 tag = `addr[ADDR_W-1:INDEX_W]`.
- `HIT_LAT`, 2: extra wait cycles on a hit, ≥0.
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `read_L1_L2`  in  1  L1 block read request, level, held until `ready_L2_L1`.
- `write_L1_L2`  in  1  L1 block write-back request, level, held until `ready_L2_L1`.
- `addr_L1_L2`  in  ADDR_W  request block address, stable while request is high.
- `ready_L2_L1`  out  1  one-cycle completion pulse to L1.
- `read_L2_MEM`  out  1  memory block read, held until `ready_MEM_L2`.
- `write_L2_MEM`  out  1  memory block write, held until `ready_MEM_L2`.
- `addr_L2_MEM`  out  ADDR_W  memory block address.
- `ready_MEM_L2`  in  1  memory completion pulse.
- `refill_L2`  out  1  write the L2 data line at `index_L2` from memory data.
- `update_L2`  out  1  write the L2 data line at `index_L2` from L1 data.
- `index_L2`  out  INDEX_W  data-array index; the captured request index.

## Operation
- FSM states: S_IDLE, S_LOOKUP, S_HIT_WAIT, S_WB, S_FILL, S_RESP, S_DONE.
- S_IDLE:
  - If any request is high, capture `addr_L1_L2` and the op, then go to S_LOOKUP.
  - Write has priority when both requests are high; the read stays pending and is served afterwards.
- S_LOOKUP: hit = `valid[idx] && tag_arr[idx]==tag`.
  - Write, hit or miss: go to S_WB if the victim is valid, dirty and tag-mismatched; otherwise S_RESP. No fill, because the L1 writes a full line.
  - Read hit: go to S_HIT_WAIT, or directly to S_RESP if `HIT_LAT`=0.
  - Read miss: go to S_WB if the victim is valid and dirty; otherwise S_FILL.
- S_HIT_WAIT: count `HIT_LAT` cycles, then go to S_RESP.
- S_WB:
  - `write_L2_MEM`=1, `addr_L2_MEM`=`{tag_arr[idx], idx}`.
  - On `ready_MEM_L2`, clear `dirty[idx]`, then go to S_FILL (read) or S_RESP (write).
- S_FILL:
  - `read_L2_MEM`=1, `addr_L2_MEM`=captured address.
  - On `ready_MEM_L2`: `refill_L2`=1 that cycle; `tag_arr[idx]`←tag, `valid`←1, `dirty`←0; go to S_RESP.
- S_RESP:
  - `ready_L2_L1`=1.
  - If the op is a write: `update_L2`=1, `tag_arr[idx]`←tag, `valid`←1, `dirty`←1.
  - Next state is S_DONE.
- S_DONE: one cooldown cycle that ignores requests, so a level still high from the L1 is not served twice. Next state is S_IDLE.
- `addr_L2_MEM` is 0 outside S_WB and S_FILL.
- Memory outputs are pure state decodes and are never asserted together.

## Timing
- All outputs are 0 on reset.
- Reset clears `valid`, `dirty` and `tag_arr` and forces S_IDLE.
- Reset asserted mid-transaction aborts it with no array update. A request still held after reset is re-served from S_IDLE.
- Read hit: request seen in S_IDLE at cycle c0; `ready_L2_L1` is high in cycle c0+2+`HIT_LAT`.
- Miss:
  - Memory request rises at c0+2.
  - Response at the cycle after the final `ready_MEM_L2`.
- Write without victim: `ready_L2_L1`/`update_L2` at c0+2.
- `ready_MEM_L2` outside S_WB/S_FILL is ignored.
- `refill_L2` is combinational from state and `ready_MEM_L2`. All other outputs decode from registered state only.
- Earliest next request acceptance is 2 cycles after `ready_L2_L1` (S_DONE, then S_IDLE).

## Structure
- Package `l2_pkg`: the state enum (3-bit), default widths and `HIT_LAT`.
- Sub-module `l2_tag_array` holds the tag, valid and dirty storage:
  - one combinational read port;
  - one synchronous write port (set-valid, set/clear-dirty, tag write);
  - asynchronous clear.
- The FSM, latency counter and captured address live in the top.

## Test plan
- After reset, read `26'h00000A5` → `read_L2_MEM`=1 with `addr_L2_MEM`=`26'h00000A5` from c2. With `ready_MEM_L2` at c5: `refill_L2`=1 at c5, `ready_L2_L1` at c6.
- Repeat read `26'h00000A5` with `HIT_LAT`=2 → `ready_L2_L1` at c4; no memory strobes.
- Write `26'h00001A5` (same index, tag 1, victim clean) → no memory access; `update_L2`=1 and `ready_L2_L1` at c2. The line becomes dirty with tag 1.
- Read `26'h00000A5` → `write_L2_MEM` with address `26'h00001A5` until `ready_MEM_L2`, then `read_L2_MEM` with `26'h00000A5`, then `ready_L2_L1`.
- Both requests held high with address `26'h0000010` → the write is served first, exactly one `ready_L2_L1` per served op, no double service during S_DONE.
- Reset asserted during S_FILL → all outputs 0 the next cycle. A following read of the same address misses.
